// File: rtl/sub_pkg.sv
// Shared types for the bit-serial subtractor: controller state encoding and
// the bit-counter width helper.
package sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // The counter must be able to hold the values 0..N.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

    localparam int CNT_W_DEFAULT = cnt_width(4);

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor built from gate primitives: d = a - b - bi,
// bo set when the position has to borrow from the next one.
module full_subtractor (
    output logic d,
    output logic bo,
    input  logic a,
    input  logic b,
    input  logic bi
);

    logic t_ab;
    logic na;
    logic x1;
    logic x2;
    logic x3;

    xor g_x1 (t_ab, a, b);
    xor g_x2 (d, t_ab, bi);

    // Borrow when the minuend bit is 0 and either b or bi is 1, or when both are 1.
    not g_n1 (na, a);
    and g_a1 (x1, na, b);
    and g_a2 (x2, na, bi);
    and g_a3 (x3, b, bi);
    or  g_o1 (bo, x1, x2, x3);

endmodule

// File: rtl/serial_ripple_subtractor.sv
// Bit-serial N-bit subtractor: DIFF = A - B - bi, one bit per clock, LSB
// first, with the borrow carried between bit positions in a flop.
module serial_ripple_subtractor
    import sub_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         bi,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] DIFF,
    output logic         bo,
    output logic         ovf,
    output logic [1:0]   dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready
    // are both 1. Input side: in_ready is 1 only in IDLE. Output side:
    // out_valid is 1 only in DONE, and DIFF/bo/ovf hold until out_ready.
    localparam int CW = cnt_width(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t          state;
    state_t          state_n;
    logic [N-1:0]    a_sr;
    logic [N-1:0]    b_sr;
    logic [N-1:0]    diff_r;
    logic            borrow;
    logic [CW-1:0]   cnt;
    logic            a_msb;
    logic            b_msb;
    logic            d_bit;
    logic            bo_bit;

    full_subtractor u_cell (
        .d  (d_bit),
        .bo (bo_bit),
        .a  (a_sr[0]),
        .b  (b_sr[0]),
        .bi (borrow)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (in_valid)     state_n = BUSY;
            BUSY:    if (cnt == LAST)  state_n = DONE;
            DONE:    if (out_ready)    state_n = IDLE;
            default:                   state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            diff_r <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sr   <= A;
                        b_sr   <= B;
                        borrow <= bi;
                        cnt    <= '0;
                        a_msb  <= A[N-1];
                        b_msb  <= B[N-1];
                    end
                end
                BUSY: begin
                    // New difference bits enter at the MSB so that after N shifts
                    // bit 0 of the result sits at DIFF[0].
                    diff_r <= (diff_r >> 1) | (N'(d_bit) << (N - 1));
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    borrow <= bo_bit;
                    cnt    <= cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign DIFF      = diff_r;
    assign bo        = borrow;
    assign ovf       = (a_msb != b_msb) & (diff_r[N-1] != a_msb);
    assign dbg_state = state;

endmodule

// File: tb/tb_serial_ripple_subtractor.sv
// Randomised and directed check of serial_ripple_subtractor (N=4) against an
// arithmetic model with a cycle-level handshake/latency tracker.
module tb_serial_ripple_subtractor;

    localparam int N = 4;
    localparam int W = N + 2;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         bi;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] DIFF;
    logic         bo;
    logic         ovf;
    logic [1:0]   dbg_state;

    int vectors;
    int miscompares;
    bit started;

    logic [W-1:0] exp_q[$];

    serial_ripple_subtractor #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .bi        (bi),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .DIFF      (DIFF),
        .bo        (bo),
        .ovf       (ovf),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic; ovf from operand and result signs.
    function automatic logic [W-1:0] model(input int a, input int b, input int c);
        int full;
        logic [N-1:0] dv;
        logic bov;
        logic ov;
        full = a - b - c;
        dv   = full[N-1:0];
        bov  = (full < 0);
        ov   = ((a >> (N-1)) != (b >> (N-1))) && (dv[N-1] != a[N-1]);
        return {dv, bov, ov};
    endfunction

    // scoreboard / cycle tracker
    int mode;
    int left;
    always @(negedge clk) begin
        if (started) begin
            if (in_ready && out_valid) begin
                miscompares++;
                $display("FAIL hs_exclusive: in_ready=1 and out_valid=1 at %0t", $time);
            end
            chk("in_ready", 32'(in_ready), 32'(mode == 0));
            chk("out_valid", 32'(out_valid), 32'(mode == 2));
            if (mode == 2) begin
                if (exp_q.size() == 0) begin
                    chk("exp_q_empty", 32'(0), 32'(1));
                end else begin
                    chk("result", 32'({DIFF, bo, ovf}), 32'(exp_q[0]));
                end
            end
            if (rst) begin
                mode = 0;
                exp_q.delete();
            end else begin
                case (mode)
                    0: if (in_valid) begin
                        mode = 1;
                        left = N;
                        exp_q.push_back(model(int'(A), int'(B), int'(bi)));
                    end
                    1: begin
                        left--;
                        if (left == 0) mode = 2;
                    end
                    default: if (out_ready) begin
                        mode = 0;
                        if (exp_q.size() != 0) void'(exp_q.pop_front());
                    end
                endcase
            end
        end
    end

    // driver: one full transaction; returns handed-off outputs and latency
    task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic c,
                         input int stall, input bit noise,
                         output logic [W-1:0] res, output int lat);
        int k;
        int st;
        bit seen;
        bit hand;
        res  = '0;
        lat  = -1;
        st   = stall;
        seen = 1'b0;
        k    = 0;
        while (!in_ready && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        if (!in_ready) chk("wait_in_ready", 32'(0), 32'(1));
        A = a; B = b; bi = c; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (k = 0; k < 100; k++) begin
            if (noise) begin
                A        = N'($urandom);
                B        = N'($urandom);
                bi       = 1'($urandom);
                in_valid = 1'($urandom);
            end
            hand = 1'b0;
            if (out_valid) begin
                if (!seen) begin
                    seen = 1'b1;
                    lat  = k;
                end
                if (st == 0) begin
                    out_ready = 1'b1;
                    res  = {DIFF, bo, ovf};
                    hand = 1'b1;
                end else begin
                    out_ready = 1'b0;
                    st--;
                end
            end
            @(posedge clk); #1;
            out_ready = 1'b0;
            if (hand) break;
        end
        in_valid = 1'b0;
        if (k >= 100) chk("op_timeout", 32'(0), 32'(1));
    endtask

    initial begin
        logic [W-1:0] r;
        int lat;
        vectors     = 0;
        miscompares = 0;
        started     = 1'b0;
        mode        = 0;
        left        = 0;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        A = '0; B = '0; bi = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_in_ready", 32'(in_ready), 32'(1));
        chk("rst_out_valid", 32'(out_valid), 32'(0));
        chk("rst_diff", 32'(DIFF), 32'(0));
        chk("rst_bo", 32'(bo), 32'(0));
        chk("rst_ovf", 32'(ovf), 32'(0));
        started = 1'b1;

        // hand-computed cases pin the model and the DUT
        do_op(4'd7, 4'd3, 1'b0, 0, 1'b0, r, lat);
        chk("7-3", 32'(r), 32'({4'h4, 1'b0, 1'b0}));
        chk("latency", 32'(lat), 32'(4));
        do_op(4'd3, 4'd7, 1'b0, 0, 1'b0, r, lat);
        chk("3-7", 32'(r), 32'({4'hC, 1'b1, 1'b0}));
        do_op(4'd0, 4'd0, 1'b1, 0, 1'b0, r, lat);
        chk("0-0-1", 32'(r), 32'({4'hF, 1'b1, 1'b0}));
        do_op(4'd8, 4'd1, 1'b0, 0, 1'b0, r, lat);
        chk("-8-1", 32'(r), 32'({4'h7, 1'b0, 1'b1}));
        do_op(4'd7, 4'hF, 1'b0, 0, 1'b0, r, lat);
        chk("7-(-1)", 32'(r), 32'({4'h8, 1'b1, 1'b1}));
        chk("model_pin", 32'(model(7, 15, 0)), 32'({4'h8, 1'b1, 1'b1}));

        // backpressure with input noise during BUSY and DONE
        do_op(4'd9, 4'd2, 1'b1, 3, 1'b1, r, lat);
        chk("bp_result", 32'(r), 32'({4'h6, 1'b0, 1'b1}));

        // reset during the second bit cycle
        @(posedge clk); #1;
        A = 4'd6; B = 4'd1; bi = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_in_ready", 32'(in_ready), 32'(1));
        chk("abort_out_valid", 32'(out_valid), 32'(0));
        chk("abort_diff", 32'(DIFF), 32'(0));
        do_op(4'd5, 4'd5, 1'b0, 0, 1'b0, r, lat);
        chk("5-5", 32'(r), 32'({4'h0, 1'b0, 1'b0}));

        // exhaustive sweep with random stalls
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int c = 0; c < 2; c++) begin
                    do_op(N'(a), N'(b), 1'(c), int'($urandom_range(0, 3)),
                          1'($urandom_range(0, 1)), r, lat);
                    chk("sweep", 32'(r), 32'(model(a, b, c)));
                end
            end
        end

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
